// File: rtl/mac_rx_udp_payload_extract_if.sv
// Byte-stream bundle between the MAC rx strip stage, the UDP payload extractor and the BFD receiver.
// The slave side consumes mac_rx_* and produces pl_*.
interface mac_rx_udp_payload_extract_if;
    logic [7:0] mac_rx_data_i;
    logic       mac_rx_valid_i;
    logic       mac_rx_sof_i;
    logic       mac_rx_eof_i;
    logic [7:0] pl_data_o;
    logic       pl_valid_o;
    logic       pl_sof_o;
    logic       pl_eof_o;
    logic       pl_err_o;

    modport slave (
        input  mac_rx_data_i, mac_rx_valid_i, mac_rx_sof_i, mac_rx_eof_i,
        output pl_data_o, pl_valid_o, pl_sof_o, pl_eof_o, pl_err_o
    );

    modport master (
        output mac_rx_data_i, mac_rx_valid_i, mac_rx_sof_i, mac_rx_eof_i,
        input  pl_data_o, pl_valid_o, pl_sof_o, pl_eof_o, pl_err_o
    );
endinterface

// File: rtl/mac_rx_udp_payload_extract.sv
// Parses Ethernet II / IPv4 (IHL=5) / UDP headers from the rx byte stream, filters on destination
// MAC/IP/port and forwards only the UDP payload with latched sender fields.
module mac_rx_udp_payload_extract #(
    parameter logic [15:0] UDP_PORT = 16'd3784,
    parameter bit          CHECK_IP = 1'b1
) (
    input  logic                               clk,
    input  logic                               rst,
    mac_rx_udp_payload_extract_if.slave        bus,
    input  logic [47:0]                        local_mac,
    input  logic [31:0]                        local_ip,
    output logic [47:0]                        src_mac_o,
    output logic [31:0]                        src_ip_o,
    output logic [15:0]                        src_port_o,
    output logic [15:0]                        cnt_pass_o,
    output logic [15:0]                        cnt_drop_o
);

    typedef enum logic [1:0] {StIdle, StHdr, StPayload, StDrop} state_e;

    state_e      state_q, state_d;
    logic [5:0]  n_q, n_d;
    logic [15:0] rem_q, rem_d;
    logic        first_q, first_d;
    logic [39:0] hdr_q, hdr_d;
    logic [15:0] udp_len_q, udp_len_d;
    logic [47:0] sh_mac_q, sh_mac_d;
    logic [31:0] sh_ip_q, sh_ip_d;
    logic [15:0] sh_port_q, sh_port_d;
    logic [7:0]  pl_data_q, pl_data_d;
    logic        pl_valid_q, pl_valid_d;
    logic        pl_sof_q, pl_sof_d;
    logic        pl_eof_q, pl_eof_d;
    logic        pl_err_q, pl_err_d;
    logic [1:0]  drop_add;
    logic        pass_inc;
    logic        start, hdr_byte, hdr_fail;
    logic [5:0]  idx;
    logic [47:0] word;
    logic [16:0] drop_sum;

    assign start    = bus.mac_rx_valid_i & bus.mac_rx_sof_i;
    assign hdr_byte = bus.mac_rx_valid_i & (bus.mac_rx_sof_i | (state_q == StHdr));
    assign idx      = start ? 6'd0 : n_q;
    // Current byte appended to the last five header bytes: every multi-byte field ends here.
    assign word     = {hdr_q, bus.mac_rx_data_i};

    always_comb begin
        hdr_fail = 1'b0;
        case (idx)
            6'd5:    hdr_fail = (word != local_mac) && (word != 48'hFFFF_FFFF_FFFF);
            6'd13:   hdr_fail = word[15:0] != 16'h0800;
            6'd14:   hdr_fail = word[7:0] != 8'h45;
            6'd23:   hdr_fail = word[7:0] != 8'h11;
            6'd33:   hdr_fail = CHECK_IP && (word[31:0] != local_ip);
            6'd37:   hdr_fail = word[15:0] != UDP_PORT;
            6'd39:   hdr_fail = word[15:0] < 16'd9;
            default: hdr_fail = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        rem_d      = rem_q;
        first_d    = first_q;
        hdr_d      = hdr_q;
        udp_len_d  = udp_len_q;
        sh_mac_d   = sh_mac_q;
        sh_ip_d    = sh_ip_q;
        sh_port_d  = sh_port_q;
        pl_data_d  = pl_data_q;
        pl_valid_d = 1'b0;
        pl_sof_d   = 1'b0;
        pl_eof_d   = 1'b0;
        pl_err_d   = 1'b0;
        drop_add   = 2'd0;
        pass_inc   = 1'b0;

        if (bus.mac_rx_valid_i) hdr_d = word[39:0];

        // A new sof terminates whatever frame was in flight, exactly like an eof would.
        if (start) begin
            if (state_q == StHdr) begin
                drop_add = drop_add + 2'd1;
            end else if (state_q == StPayload) begin
                pl_eof_d = 1'b1;
                pl_err_d = 1'b1;
            end
        end

        if (hdr_byte) begin
            state_d = StHdr;
            n_d     = idx + 6'd1;
            case (idx)
                6'd11:   sh_mac_d  = word;
                6'd29:   sh_ip_d   = word[31:0];
                6'd35:   sh_port_d = word[15:0];
                6'd39:   udp_len_d = word[15:0];
                default: ;
            endcase
            if (hdr_fail) begin
                state_d  = StDrop;
                drop_add = drop_add + 2'd1;
            end else if (idx == 6'd41) begin
                state_d = StPayload;
                rem_d   = udp_len_q - 16'd8;
                first_d = 1'b1;
            end
        end else if ((state_q == StPayload) && bus.mac_rx_valid_i) begin
            pl_valid_d = 1'b1;
            pl_data_d  = bus.mac_rx_data_i;
            pl_sof_d   = first_q;
            first_d    = 1'b0;
            rem_d      = rem_q - 16'd1;
            if (rem_q == 16'd1) begin
                pl_eof_d = 1'b1;
                pass_inc = 1'b1;
                state_d  = StDrop;
            end
        end

        if (bus.mac_rx_eof_i) begin
            state_d = StIdle;
            if (hdr_byte || (state_q == StHdr)) begin
                if (!(hdr_byte && hdr_fail)) drop_add = drop_add + 2'd1;
            end else if ((state_q == StPayload) && !pl_eof_d) begin
                pl_eof_d = 1'b1;
                pl_err_d = 1'b1;
            end
        end
    end

    assign drop_sum = {1'b0, cnt_drop_o} + {15'd0, drop_add};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            n_q        <= '0;
            rem_q      <= '0;
            first_q    <= 1'b0;
            hdr_q      <= '0;
            udp_len_q  <= '0;
            sh_mac_q   <= '0;
            sh_ip_q    <= '0;
            sh_port_q  <= '0;
            pl_data_q  <= '0;
            pl_valid_q <= 1'b0;
            pl_sof_q   <= 1'b0;
            pl_eof_q   <= 1'b0;
            pl_err_q   <= 1'b0;
            src_mac_o  <= '0;
            src_ip_o   <= '0;
            src_port_o <= '0;
            cnt_pass_o <= '0;
            cnt_drop_o <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            rem_q      <= rem_d;
            first_q    <= first_d;
            hdr_q      <= hdr_d;
            udp_len_q  <= udp_len_d;
            sh_mac_q   <= sh_mac_d;
            sh_ip_q    <= sh_ip_d;
            sh_port_q  <= sh_port_d;
            pl_data_q  <= pl_data_d;
            pl_valid_q <= pl_valid_d;
            pl_sof_q   <= pl_sof_d;
            pl_eof_q   <= pl_eof_d;
            pl_err_q   <= pl_err_d;
            if (pl_sof_d) begin
                src_mac_o  <= sh_mac_q;
                src_ip_o   <= sh_ip_q;
                src_port_o <= sh_port_q;
            end
            if (pass_inc && (cnt_pass_o != 16'hFFFF)) cnt_pass_o <= cnt_pass_o + 16'd1;
            cnt_drop_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign bus.pl_data_o  = pl_data_q;
    assign bus.pl_valid_o = pl_valid_q;
    assign bus.pl_sof_o   = pl_sof_q;
    assign bus.pl_eof_o   = pl_eof_q;
    assign bus.pl_err_o   = pl_err_q;

endmodule
